// File: rtl/data_ram_resp.sv
// Data-memory responder for the ME stage: word store with per-byte write lanes,
// optional wait states with a stall request, and combinational access-error flag.
module data_ram_resp #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stall_req_o,
   output logic        err_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              oor;
   logic              sel_ok;
   logic              acc_err;
   logic              acc_ok;
   logic              unused_addr_lsb;

   assign idx             = addr_i[ADDR_W+1:2];
   assign oor             = |addr_i[31:ADDR_W+2];
   assign unused_addr_lsb = ^addr_i[1:0];

   always_comb begin
      sel_ok = 1'b0;
      case (sel_i)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: sel_ok = 1'b1;
         default:                   sel_ok = 1'b0;
      endcase
   end

   // sel legality only matters for stores; loads always return the full word
   assign acc_err = ce_i & (oor | (we_i & ~sel_ok));
   assign acc_ok  = ce_i & ~acc_err;
   assign err_o   = ~rst & acc_err;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [3:0]        wr_sel;
   logic [31:0]       wr_data;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_sel[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   generate
      if (WAIT_CYCLES == 0) begin : g_fast
         assign wr_en       = ~rst & acc_ok & we_i;
         assign wr_idx      = idx;
         assign wr_sel      = sel_i;
         assign wr_data     = data_i;
         assign stall_req_o = 1'b0;
         assign data_o      = (~rst & acc_ok & ~we_i) ? mem[idx] : 32'h0;
      end else begin : g_wait
         typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

         state_t            state, state_nx;
         logic [3:0]        cnt, cnt_nx;
         logic              q_we;
         logic [3:0]        q_sel;
         logic [ADDR_W-1:0] q_idx;
         logic [31:0]       q_data;
         logic [31:0]       rdata_q;
         logic              latch, commit, capture, stall;

         always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            latch    = 1'b0;
            commit   = 1'b0;
            capture  = 1'b0;
            stall    = 1'b0;
            case (state)
               S_IDLE: begin
                  if (acc_ok) begin
                     stall    = 1'b1;
                     latch    = 1'b1;
                     cnt_nx   = 4'(WAIT_CYCLES - 1);
                     state_nx = S_WAIT;
                  end
               end
               S_WAIT: begin
                  stall = 1'b1;
                  if (!ce_i) begin
                     // requester flushed the access: drop it without writing
                     cnt_nx   = 4'd0;
                     state_nx = S_IDLE;
                  end else if (cnt != 4'd0) begin
                     cnt_nx = cnt - 4'd1;
                  end else begin
                     commit   = q_we;
                     capture  = ~q_we;
                     state_nx = S_DONE;
                  end
               end
               S_DONE:  state_nx = S_IDLE;
               default: state_nx = S_IDLE;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state   <= S_IDLE;
               cnt     <= 4'd0;
               rdata_q <= 32'h0;
            end else begin
               state <= state_nx;
               cnt   <= cnt_nx;
               if (capture) rdata_q <= mem[q_idx];
            end
         end

         // requester may change addr/data mid-access; only the latched copy is used
         always_ff @(posedge clk) begin
            if (latch) begin
               q_we   <= we_i;
               q_sel  <= sel_i;
               q_idx  <= idx;
               q_data <= data_i;
            end
         end

         assign wr_en       = ~rst & commit;
         assign wr_idx      = q_idx;
         assign wr_sel      = q_sel;
         assign wr_data     = q_data;
         assign stall_req_o = ~rst & stall;
         assign data_o      = (~rst && state == S_DONE && !q_we) ? rdata_q : 32'h0;
      end
   endgenerate
endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: a zero-wait and a two-wait instance checked every cycle
// against a word-array model plus directed literal expectations.
module tb_data_ram_resp;
   localparam int AW = 10;
   localparam int WB = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_ce, a_we, a_stall, a_err;
   logic [3:0]  a_sel;
   logic [31:0] a_addr, a_data, a_rd;
   logic        b_ce, b_we, b_stall, b_err;
   logic [3:0]  b_sel;
   logic [31:0] b_addr, b_data, b_rd;

   data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_a (
      .clk(clk), .rst(rst), .ce_i(a_ce), .we_i(a_we), .sel_i(a_sel),
      .addr_i(a_addr), .data_i(a_data), .data_o(a_rd),
      .stall_req_o(a_stall), .err_o(a_err));

   data_ram_resp #(.ADDR_W(AW), .WAIT_CYCLES(WB)) u_b (
      .clk(clk), .rst(rst), .ce_i(b_ce), .we_i(b_we), .sel_i(b_sel),
      .addr_i(b_addr), .data_i(b_data), .data_o(b_rd),
      .stall_req_o(b_stall), .err_o(b_err));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_a [int];
   logic [31:0] model_b [int];
   logic        exp_b_stall;
   logic [31:0] exp_b_data;

   function automatic logic bad(input logic ce, input logic we,
                                input logic [3:0] sel, input logic [31:0] addr);
      logic sel_ok;
      sel_ok = sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0011, 4'b1100, 4'b1111};
      return ce && (((addr >> (AW + 2)) != 0) || (we && !sel_ok));
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'(addr >> 2) % (1 << AW);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] w;
      w = old;
      for (int k = 0; k < 4; k++) if (sel[k]) w[8*k +: 8] = d[8*k +: 8];
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      logic        ea, eb;
      logic [31:0] ed;
      int          i;
      ea = !rst && bad(a_ce, a_we, a_sel, a_addr);
      i  = widx(a_addr);
      ed = 32'h0;
      if (!rst && a_ce && !a_we && !ea) ed = model_a.exists(i) ? model_a[i] : 32'h0;
      chk("a_err", a_err, ea);
      chk("a_stall", a_stall, 1'b0);
      chk("a_data", a_rd, ed);
      eb = !rst && bad(b_ce, b_we, b_sel, b_addr);
      chk("b_err", b_err, eb);
      chk("b_stall", b_stall, rst ? 1'b0 : exp_b_stall);
      chk("b_data", b_rd, rst ? 32'h0 : exp_b_data);
      if (!rst && a_ce && a_we && !ea)
         model_a[i] = merge(model_a.exists(i) ? model_a[i] : 32'h0, a_data, a_sel);
   end

   task automatic a_cyc(input logic ce, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      a_ce = ce; a_we = we; a_sel = sel; a_addr = addr; a_data = data;
   endtask

   task automatic sample;
      @(negedge clk); #1;
   endtask

   // one access on the wait-state instance; addr/data are scrambled after the
   // first cycle to show the responder works from its latched copy
   task automatic b_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] data, input int flush_at,
                           output logic [31:0] rd, output int nstall);
      logic e;
      int   n, i;
      e = bad(1'b1, we, sel, addr);
      n = e ? 1 : WB + 2;
      i = widx(addr);
      rd = 32'h0;
      nstall = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         b_ce   = (c != flush_at);
         b_we   = we;
         b_sel  = sel;
         b_addr = (c == 0) ? addr : addr ^ 32'h4;
         b_data = (c == 0) ? data : ~data;
         exp_b_stall = !e && (c <= WB);
         exp_b_data  = (!e && c == WB + 1 && !we) ? model_b[i] : 32'h0;
         sample;
         if (b_stall) nstall++;
         if (c == WB + 1) rd = b_rd;
         if (c == flush_at) return;
      end
      if (!e && we) model_b[i] = merge(model_b.exists(i) ? model_b[i] : 32'h0, data, sel);
   endtask

   task automatic b_idle;
      @(posedge clk); #1;
      b_ce = 1'b0; b_we = 1'b0; exp_b_stall = 1'b0; exp_b_data = 32'h0;
   endtask

   initial begin
      logic [31:0] rd;
      int          ns;
      rst = 1'b1;
      a_ce = 0; a_we = 0; a_sel = 0; a_addr = 0; a_data = 0;
      b_ce = 0; b_we = 0; b_sel = 0; b_addr = 0; b_data = 0;
      exp_b_stall = 1'b0; exp_b_data = 32'h0;

      // outputs forced low during reset even with active requests
      a_cyc(1, 0, 4'h0, 32'h40, 32'h0);
      sample; chk("rst_a_data", a_rd, 32'h0);
      a_cyc(1, 1, 4'hF, 32'h0001_0000, 32'h0);
      sample; chk("rst_a_err", a_err, 1'b0);
      @(posedge clk); #1; rst = 1'b0; a_ce = 1'b0;

      // zero-wait instance
      a_cyc(1, 1, 4'hF, 32'h40, 32'h1122_3344);
      a_cyc(1, 0, 4'h0, 32'h40, 32'h0);
      sample; chk("a_lw_word", a_rd, 32'h1122_3344); chk("a_lw_stall", a_stall, 1'b0);
      a_cyc(1, 1, 4'b0010, 32'h41, 32'hAAAA_AAAA);
      a_cyc(1, 1, 4'b1100, 32'h42, 32'h5566_5566);
      a_cyc(1, 0, 4'h0, 32'h40, 32'h0);
      sample; chk("a_lw_merged", a_rd, 32'h5566_AA44);
      a_cyc(1, 1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
      sample; chk("a_oor_err", a_err, 1'b1); chk("a_oor_stall", a_stall, 1'b0);
      a_cyc(1, 1, 4'b0000, 32'h40, 32'hFFFF_FFFF);
      sample; chk("a_sel0000_err", a_err, 1'b1);
      a_cyc(1, 1, 4'b0110, 32'h40, 32'hFFFF_FFFF);
      sample; chk("a_sel0110_err", a_err, 1'b1);
      a_cyc(1, 0, 4'h0, 32'h40, 32'h0);
      sample; chk("a_after_err", a_rd, 32'h5566_AA44);
      a_cyc(1, 0, 4'h0, 32'h0001_0040, 32'h0);
      sample; chk("a_oor_load_err", a_err, 1'b1); chk("a_oor_load_data", a_rd, 32'h0);
      a_cyc(0, 1, 4'h0, 32'h0001_0000, 32'h0);
      sample; chk("a_idle_err", a_err, 1'b0);
      a_cyc(0, 0, 4'h0, 32'h0, 32'h0);

      // wait-state instance
      b_access(1, 4'hF, 32'h40, 32'h1122_3344, -1, rd, ns);
      b_access(1, 4'b0010, 32'h41, 32'hAAAA_AAAA, -1, rd, ns);
      b_access(1, 4'b1100, 32'h42, 32'h5566_5566, -1, rd, ns);
      b_access(0, 4'h0, 32'h40, 32'h0, -1, rd, ns);
      chk("b_lw_merged", rd, 32'h5566_AA44); chk("b_lw_stall_cycles", ns, 3);
      b_access(1, 4'hF, 32'h80, 32'h0123_4567, -1, rd, ns);
      b_access(1, 4'hF, 32'h80, 32'hDEAD_BEEF, 1, rd, ns);
      b_access(0, 4'h0, 32'h80, 32'h0, -1, rd, ns);
      chk("b_flush_nowrite", rd, 32'h0123_4567);
      b_access(1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF, -1, rd, ns);
      chk("b_oor_stall_cycles", ns, 0);
      b_access(1, 4'b0110, 32'h40, 32'hFFFF_FFFF, -1, rd, ns);
      b_access(0, 4'h0, 32'h40, 32'h0, -1, rd, ns);
      chk("b_after_err", rd, 32'h5566_AA44);
      b_access(1, 4'hF, 32'hC0, 32'h0BAD_F00D, -1, rd, ns);

      // reset in the last WAIT cycle of a store must drop the write
      @(posedge clk); #1;
      b_ce = 1; b_we = 1; b_sel = 4'hF; b_addr = 32'hC0; b_data = 32'hCAFE_BABE;
      exp_b_stall = 1'b1; exp_b_data = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b1;
      sample; chk("rst_b_stall", b_stall, 1'b0);
      @(posedge clk); #1; rst = 1'b0; b_ce = 1'b0; exp_b_stall = 1'b0;
      sample; chk("post_rst_stall", b_stall, 1'b0); chk("post_rst_data", b_rd, 32'h0);
      b_access(0, 4'h0, 32'hC0, 32'h0, -1, rd, ns);
      chk("b_rst_nowrite", rd, 32'h0BAD_F00D);
      b_idle;
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
